melody_sequencer: RTL and testbench
===================================

# melody_sequencer

Parametrised successor to the single-song tempo FSM in the music engine. It steps through a note score held in an external synchronous ROM, one note per tempo period. It supports multiple songs, a programmable song length, start/stop/pause control and optional looping. It drives a note code to the tone generator and reports progress to the game controller.

## Interface
Parameters:
- NOTE_W, 5: width of a note code.
- STEP_W, 7: step index width; a song holds at most 2^STEP_W steps.
- SONG_W, 2: song select width; up to 2^SONG_W songs in the ROM.
- TEMPO_DIV, 5000000: clock cycles per step; must be ≥ 2.
- REST_CODE, 25: note code meaning silence; driven whenever the sequencer is not playing.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin playback; sampled only in IDLE.
- stop  in  1  abort playback; has priority over every other input.
- pause  in  1  freeze playback while high.
- loop_en  in  1  restart at step 0 after the last step instead of ending.
- song_sel  in  SONG_W  song to play; latched on start.
- last_step  in  STEP_W  index of the final step; latched on start. The song plays last_step+1 steps.
- rom_addr  out  SONG_W+STEP_W  registered ROM address {song, step}.
- rom_data  in  NOTE_W  ROM read data; valid one cycle after rom_addr changes (1-cycle synchronous read).
- note  out  NOTE_W  current note code (registered).
- note_valid  out  1  high while a score note is being driven.
- step  out  STEP_W  index of the note currently on `note`.
- step_tick  out  1  one-cycle pulse on each cycle where `note` loads a new score entry.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a non-looping song ends naturally.

## Operation
- States: IDLE, PRIME0, PRIME1, PLAY.
- **IDLE.**
  - When start=1 and stop=0: latch song_sel and last_step, set rom_addr={song_sel,0}, set step=0, go to PRIME0.
- **PRIME0.** Waits for ROM latency, then goes to PRIME1.
- **PRIME1.** Captures the first note and enters PLAY:
  - note←rom_data, note_valid←1, step_tick pulses.
  - tick counter cleared to 0.
  - rom_addr←{song, next(step)}.
- **next(s).** Equals 0 if s==last_step, otherwise s+1 (STEP_W-bit wrap is never reached beyond last_step).
- **PLAY.**
  - The tick counter increments each cycle when pause=0 and holds when pause=1.
  - At tick==TEMPO_DIV-1 with pause=0, the step ends:
    - If step!=last_step, or loop_en=1: note←rom_data, step←next(step), step_tick pulses, tick←0, rom_addr←{song, next(next(step))}.
    - If step==last_step and loop_en=0: note←REST_CODE, note_valid←0, done pulses, go to IDLE.
- **Prefetch.** rom_addr is constant for at least TEMPO_DIV-1 cycles before each capture, so rom_data is always settled when captured.
- **stop=1 in any non-IDLE state.** Next cycle: IDLE, note=REST_CODE, note_valid=0, no done pulse. rom_addr and step are left unchanged.
- **Input changes during playback.** song_sel and last_step changes are ignored (latched copies are used). start is ignored while busy.
- **pause.** Has no effect in IDLE, PRIME0 or PRIME1; the priming sequence always completes.

## Timing
- Reset values: note=REST_CODE, note_valid=0, step=0, rom_addr=0, step_tick=0, busy=0, done=0, state IDLE, tick=0.
- Start latency: start sampled at edge E0 → first note on `note` after edge E2, with step_tick high in the cycle after E2.
- busy rises after E0.
- Each note is held exactly TEMPO_DIV cycles when pause is not asserted, plus one cycle for each cycle pause is high.
- Loop wrap: step 0 follows last_step with no gap or extra cycle.
- End of song: done and note=REST_CODE appear together, TEMPO_DIV cycles after the last note loaded. busy falls in the same cycle.
- A new start is accepted in the cycle after done.
- Reset asserted mid-song takes effect immediately (asynchronously), with the outputs above. Playback does not resume after reset deasserts.

## Test plan
All scenarios use TEMPO_DIV=4, STEP_W=3, SONG_W=1. The ROM model holds song0 = 10,13,18,22,… and song1 = 1,2,3,4,5,6,7,8.

1. Reset → note=25, note_valid=0, busy=0. Start with song_sel=0, last_step=3, loop_en=0 → notes 10,13,18,22 each held 4 cycles, first note 2 cycles after start. Then done pulses once, note=25, busy=0.
2. song_sel=1, last_step=7, loop_en=1 → sequence 1..8,1,2,… with no gap at the wrap. step_tick occurs every 4 cycles.
3. song0 playing, pause held for 5 cycles mid-note → that note lasts 9 cycles, the next note is correct, and step is unchanged during the pause.
4. stop asserted during the third note → IDLE next cycle, note=25, no done pulse. start in the following cycle → replays from step 0.
5. start pulsed during playback, and song_sel changed mid-song → both ignored, and the playing song and length are unchanged. start and stop together in IDLE → stays IDLE.
6. Reset asserted during PRIME1 and again during PLAY → outputs take their reset values immediately. No further step_tick until a new start.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a note score held in an external
// synchronous ROM, one note per TEMPO_DIV clock cycles, with song select,
// programmable length, start/stop/pause and optional looping.
module melody_sequencer #(
    parameter int NOTE_W    = 5,
    parameter int STEP_W    = 7,
    parameter int SONG_W    = 2,
    parameter int TEMPO_DIV = 5000000,
    parameter int REST_CODE = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop_en,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic [STEP_W-1:0]        last_step,
    output logic [SONG_W+STEP_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0]        rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic                     note_valid,
    output logic [STEP_W-1:0]        step,
    output logic                     step_tick,
    output logic                     busy,
    output logic                     done
);

    localparam int TICK_W = (TEMPO_DIV > 2) ? $clog2(TEMPO_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TEMPO_DIV - 1);
    localparam logic [NOTE_W-1:0] REST      = NOTE_W'(REST_CODE);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME0 = 2'd1;
    localparam logic [1:0] S_PRIME1 = 2'd2;
    localparam logic [1:0] S_PLAY   = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [TICK_W-1:0]        tick_q, tick_d;
    logic [SONG_W-1:0]        song_q, song_d;
    logic [STEP_W-1:0]        last_q, last_d;
    logic [SONG_W+STEP_W-1:0] rom_addr_q, rom_addr_d;
    logic [NOTE_W-1:0]        note_q, note_d;
    logic                     note_valid_q, note_valid_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     step_tick_q, step_tick_d;
    logic                     done_q, done_d;

    // Successor of a step within the latched song length (wraps to 0).
    function automatic logic [STEP_W-1:0] next_step(input logic [STEP_W-1:0] s,
                                                    input logic [STEP_W-1:0] lst);
        return (s == lst) ? '0 : s + 1'b1;
    endfunction

    logic [STEP_W-1:0] step_nx;
    assign step_nx = next_step(step_q, last_q);

    // Next-state logic: stop overrides everything outside IDLE; the ROM
    // address always runs one step ahead of the note being played.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        song_d       = song_q;
        last_d       = last_q;
        rom_addr_d   = rom_addr_q;
        note_d       = note_q;
        note_valid_d = note_valid_q;
        step_d       = step_q;
        step_tick_d  = 1'b0;
        done_d       = 1'b0;
        if (state_q == S_IDLE) begin
            if (start && !stop) begin
                song_d     = song_sel;
                last_d     = last_step;
                rom_addr_d = {song_sel, {STEP_W{1'b0}}};
                step_d     = '0;
                state_d    = S_PRIME0;
            end
        end else if (stop) begin
            state_d      = S_IDLE;
            note_d       = REST;
            note_valid_d = 1'b0;
            tick_d       = '0;
        end else begin
            case (state_q)
                S_PRIME0: state_d = S_PRIME1;
                S_PRIME1: begin
                    note_d       = rom_data;
                    note_valid_d = 1'b1;
                    step_tick_d  = 1'b1;
                    tick_d       = '0;
                    rom_addr_d   = {song_q, step_nx};
                    state_d      = S_PLAY;
                end
                S_PLAY: begin
                    if (!pause) begin
                        if (tick_q != TICK_LAST) begin
                            tick_d = tick_q + 1'b1;
                        end else if (step_q != last_q || loop_en) begin
                            note_d      = rom_data;
                            step_d      = step_nx;
                            step_tick_d = 1'b1;
                            tick_d      = '0;
                            rom_addr_d  = {song_q, next_step(step_nx, last_q)};
                        end else begin
                            note_d       = REST;
                            note_valid_d = 1'b0;
                            done_d       = 1'b1;
                            tick_d       = '0;
                            state_d      = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with asynchronous reset to the silent IDLE state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tick_q       <= '0;
            song_q       <= '0;
            last_q       <= '0;
            rom_addr_q   <= '0;
            note_q       <= REST;
            note_valid_q <= 1'b0;
            step_q       <= '0;
            step_tick_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            song_q       <= song_d;
            last_q       <= last_d;
            rom_addr_q   <= rom_addr_d;
            note_q       <= note_d;
            note_valid_q <= note_valid_d;
            step_q       <= step_d;
            step_tick_q  <= step_tick_d;
            done_q       <= done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note       = note_q;
    assign note_valid = note_valid_q;
    assign step       = step_q;
    assign step_tick  = step_tick_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: vector table for a full non-looping song,
// hand sequences for pause/stop/reset corners, and randomized runs checked
// against an elapsed-cycle model of the score.
module tb_melody_sequencer;
    localparam int NW = 5, SW = 3, GW = 1, TD = 4, RC = 25;

    logic          clk = 1'b0;
    logic          reset, start, stop, pause, loop_en;
    logic [GW-1:0] song_sel;
    logic [SW-1:0] last_step;
    logic [GW+SW-1:0] rom_addr;
    logic [NW-1:0] rom_data, note;
    logic          note_valid, step_tick, busy, done;
    logic [SW-1:0] step;

    int vectors = 0;
    int miscompares = 0;

    melody_sequencer #(.NOTE_W(NW), .STEP_W(SW), .SONG_W(GW), .TEMPO_DIV(TD), .REST_CODE(RC)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .song_sel(song_sel), .last_step(last_step),
        .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
        .note_valid(note_valid), .step(step), .step_tick(step_tick),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Score ROM: song0 then song1, 1-cycle synchronous read.
    logic [NW-1:0] rom [0:15];
    initial begin
        int s0 [8] = '{10, 13, 18, 22, 11, 12, 14, 15};
        for (int i = 0; i < 8; i++) begin
            rom[i]     = NW'(s0[i]);
            rom[i + 8] = NW'(i + 1);
        end
    end
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic st, sp, pa, lp;
        logic [GW-1:0] sg;
        logic [SW-1:0] ls;
        logic [NW-1:0] nt;
        logic nv;
        logic [SW-1:0] stp;
        logic tk, bz, dn;
    } vec_t;

    function automatic vec_t mk(input logic st, sp, input int sg, ls, nt,
                                input logic nv, input int stp, input logic tk, bz, dn);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = 1'b0; v.lp = 1'b0;
        v.sg = GW'(sg); v.ls = SW'(ls); v.nt = NW'(nt); v.nv = nv;
        v.stp = SW'(stp); v.tk = tk; v.bz = bz; v.dn = dn;
        return v;
    endfunction

    // Randomized playback run against a model: after the first note loads,
    // the note index is simply (unpaused edges elapsed) / TD.
    task automatic run_rand(input int sg, input int ls, input int lp,
                            input int max_cyc, input int pause_pct);
        int a, idx, len, p;
        bit fin;
        len = ls + 1;
        a = 0;
        fin = 0;
        start = 1; stop = 0; song_sel = GW'(sg); last_step = SW'(ls); loop_en = lp[0];
        pause = 1'($urandom);
        cyc();
        start = 0;
        chk("rnd.e0.busy", busy, 1);
        chk("rnd.e0.note", note, RC);
        song_sel = GW'($urandom); last_step = SW'($urandom); pause = 1'($urandom);
        cyc();
        chk("rnd.e1.busy", busy, 1);
        chk("rnd.e1.valid", note_valid, 0);
        song_sel = GW'($urandom); last_step = SW'($urandom); pause = 1'($urandom);
        cyc();
        chk("rnd.first.note", note, rom[sg * 8]);
        chk("rnd.first.tick", step_tick, 1);
        chk("rnd.first.step", step, 0);
        chk("rnd.first.addr", rom_addr, sg * 8 + (1 % len));
        for (int c = 0; c < max_cyc && !fin; c++) begin
            p = ($urandom_range(99) < pause_pct) ? 1 : 0;
            pause = p[0];
            start = 1'($urandom);
            song_sel = GW'($urandom);
            last_step = SW'($urandom);
            cyc();
            if (p == 0) a++;
            idx = a / TD;
            if (lp == 0 && idx == len) begin
                chk("rnd.end.done", done, 1);
                chk("rnd.end.busy", busy, 0);
                chk("rnd.end.note", note, RC);
                chk("rnd.end.valid", note_valid, 0);
                fin = 1;
            end else begin
                chk("rnd.note", note, rom[sg * 8 + idx % len]);
                chk("rnd.step", step, idx % len);
                chk("rnd.tick", step_tick, (p == 0 && a % TD == 0) ? 1 : 0);
                chk("rnd.busy", busy, 1);
                chk("rnd.done", done, 0);
                chk("rnd.addr", rom_addr, sg * 8 + (idx + 1) % len);
            end
        end
        start = 0; pause = 0;
        if (fin) begin
            cyc();
            chk("rnd.post.done", done, 0);
        end else begin
            if (lp == 0) chk("rnd.timeout", 0, 1);
            stop = 1;
            cyc();
            stop = 0;
            chk("rnd.stop.busy", busy, 0);
            chk("rnd.stop.note", note, RC);
            chk("rnd.stop.done", done, 0);
            chk("rnd.stop.step", step, idx % len);
        end
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".note"}, note, RC);
        chk({tag, ".valid"}, note_valid, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".step"}, step, 0);
        chk({tag, ".addr"}, rom_addr, 0);
        chk({tag, ".tick"}, step_tick, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    task automatic quiet_after_reset(input string tag);
        int ticks = 0, bz = 0;
        cyc();
        reset = 0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            ticks += int'(step_tick);
            bz += int'(busy);
        end
        chk({tag, ".ticks"}, ticks, 0);
        chk({tag, ".busycyc"}, bz, 0);
    endtask

    vec_t tbl [21];

    initial begin
        int dur, bad, cnt;
        // Full non-looping song0, length 4, preceded by start+stop in IDLE.
        tbl[0] = mk(1, 1, 0, 3, RC, 0, 0, 0, 0, 0);
        tbl[1] = mk(1, 0, 0, 3, RC, 0, 0, 0, 1, 0);
        tbl[2] = mk(0, 0, 0, 3, RC, 0, 0, 0, 1, 0);
        tbl[3] = mk(0, 0, 0, 3, 10, 1, 0, 1, 1, 0);
        tbl[4] = mk(0, 0, 0, 3, 10, 1, 0, 0, 1, 0);
        tbl[5] = mk(0, 0, 0, 3, 10, 1, 0, 0, 1, 0);
        tbl[6] = mk(0, 0, 0, 3, 10, 1, 0, 0, 1, 0);
        tbl[7] = mk(0, 0, 0, 3, 13, 1, 1, 1, 1, 0);
        tbl[8] = mk(0, 0, 0, 3, 13, 1, 1, 0, 1, 0);
        tbl[9] = mk(0, 0, 0, 3, 13, 1, 1, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 3, 13, 1, 1, 0, 1, 0);
        tbl[11] = mk(0, 0, 0, 3, 18, 1, 2, 1, 1, 0);
        tbl[12] = mk(0, 0, 0, 3, 18, 1, 2, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 3, 18, 1, 2, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 3, 18, 1, 2, 0, 1, 0);
        tbl[15] = mk(0, 0, 0, 3, 22, 1, 3, 1, 1, 0);
        tbl[16] = mk(0, 0, 0, 3, 22, 1, 3, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 3, 22, 1, 3, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 3, 22, 1, 3, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 3, RC, 0, 3, 0, 0, 1);
        tbl[20] = mk(0, 0, 0, 3, RC, 0, 3, 0, 0, 0);

        reset = 1; start = 0; stop = 0; pause = 0; loop_en = 0;
        song_sel = 0; last_step = 0;
        #1;
        reset_check("reset");
        cyc(); cyc();
        reset = 0;
        cyc();

        for (int i = 0; i < 21; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; pause = tbl[i].pa;
            loop_en = tbl[i].lp; song_sel = tbl[i].sg; last_step = tbl[i].ls;
            cyc();
            chk($sformatf("tbl%0d.note", i), note, tbl[i].nt);
            chk($sformatf("tbl%0d.valid", i), note_valid, tbl[i].nv);
            chk($sformatf("tbl%0d.step", i), step, tbl[i].stp);
            chk($sformatf("tbl%0d.tick", i), step_tick, tbl[i].tk);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].bz);
            chk($sformatf("tbl%0d.done", i), done, tbl[i].dn);
        end
        start = 0; stop = 0;

        // Pause for 5 cycles in the middle of the second note.
        start = 1; song_sel = 0; last_step = 3; loop_en = 0;
        cyc(); start = 0;
        for (int c = 0; c < 6; c++) cyc();
        chk("pause.second", note, 13);
        dur = 1; bad = 0;
        for (int c = 0; c < 20; c++) begin
            pause = (c >= 1 && c < 6);
            cyc();
            if (note != 13) break;
            dur++;
            if (step != 1) bad++;
        end
        pause = 0;
        chk("pause.dur", dur, 9);
        chk("pause.stepheld", bad, 0);
        chk("pause.next", note, 18);
        cnt = 0;
        while (busy && cnt < 50) begin cyc(); cnt++; end
        chk("pause.ends", busy, 0);

        // Stop during the third note, then restart from step 0.
        cyc();
        start = 1; song_sel = 0; last_step = 3; loop_en = 0;
        cyc(); start = 0;
        for (int c = 0; c < 11; c++) cyc();
        chk("stop.third", note, 18);
        stop = 1;
        cyc();
        stop = 0;
        chk("stop.busy", busy, 0);
        chk("stop.note", note, RC);
        chk("stop.done", done, 0);
        start = 1;
        cyc(); start = 0;
        chk("stop.done2", done, 0);
        cyc(); cyc();
        chk("restart.note", note, 10);
        chk("restart.step", step, 0);
        stop = 1; cyc(); stop = 0;

        // Long looping song1: wrap from 8 back to 1 without gaps.
        run_rand(1, 7, 1, 80, 0);

        // Asynchronous reset during PRIME1, then during PLAY.
        start = 1; song_sel = 1; last_step = 5; loop_en = 1;
        cyc(); start = 0;
        cyc();
        #2 reset = 1;
        #1 reset_check("rst.prime1");
        quiet_after_reset("rst.prime1");
        start = 1;
        cyc(); start = 0;
        for (int c = 0; c < 7; c++) cyc();
        chk("rst.play.pre", busy, 1);
        #2 reset = 1;
        #1 reset_check("rst.play");
        quiet_after_reset("rst.play");

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            int sg, ls, lp;
            sg = $urandom_range(1);
            ls = $urandom_range(7);
            lp = $urandom_range(1);
            run_rand(sg, ls, lp, (lp != 0) ? 60 : 400, (r % 2 != 0) ? 30 : 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
